ser_collect: RTL and testbench
==============================

SER_COLLECT -- requirements
Module: ser_collect

Interface
REQ-001 SHALL have parameter: WIDTH, 16, word length in bits (2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle pulse marking the start of a serial word.
REQ-005 SHALL have port: sin  input  1  serial data, LSB first, one bit per clock.
REQ-006 SHALL have port: out_ready  input  1  consumer accepts dout when high with out_valid.
REQ-007 SHALL have port: dout  output  WIDTH  assembled parallel word.
REQ-008 SHALL have port: out_valid  output  1  dout holds an unaccepted word.
REQ-009 SHALL have port: busy  output  1  high while bits are being collected.
REQ-010 SHALL have port (only with SER_COLLECT_OVERRUN_EN): overrun  output  1  sticky overwrite flag.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, SHIFT; busy = (state == SHIFT), registered.
REQ-012 IDLE: start=1 at an edge SHALL go to SHIFT, clear the bit counter to 0, and not sample sin on that edge.
REQ-013 IDLE: start=0 SHALL hold state; sin SHALL be ignored.
REQ-014 SHIFT: each edge SHALL shift the internal register right by one, insert sin at bit WIDTH-1, and increment the counter.
REQ-015 SHIFT: start SHALL be ignored (no restart mid-word).
REQ-016 The edge sampling bit WIDTH-1 (counter = WIDTH-1) SHALL load dout with the completed word (first-sampled bit at dout[0]), set out_valid, and return to IDLE.
REQ-017 Latency: out_valid SHALL rise on the edge WIDTH cycles after the edge that sampled start.
REQ-018 Back-to-back: start high on the completion edge SHALL be ignored; the next word needs start at or after the following edge.
REQ-019 dout SHALL stay stable while out_valid=1, except as REQ-022 states.
REQ-020 out_valid=1 and out_ready=1 at an edge with no word completing SHALL clear out_valid at that edge.
REQ-021 Accept and completion on the same edge SHALL load the new word and keep out_valid=1.
REQ-022 Completion while out_valid=1 and out_ready=0 SHALL overwrite dout with the new word and keep out_valid=1.
REQ-023 out_ready SHALL have no effect while out_valid=0.
REQ-024 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap inside SHIFT.

Reset
REQ-025 reset=1 SHALL immediately, without a clock edge, force IDLE, counter 0, shift register 0, dout 0, out_valid 0, busy 0, and overrun 0.
REQ-026 reset mid-word SHALL discard the partial word; no out_valid SHALL follow from it.
REQ-027 After reset deasserts, the first edge with start=1 SHALL begin a new word.

Configuration
REQ-028 SER_COLLECT_OVERRUN_EN defined: the overrun port SHALL exist and SHALL set on any REQ-022 event.
REQ-029 Once set, overrun SHALL stay set until reset.
REQ-030 SER_COLLECT_OVERRUN_EN undefined: the overrun port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL drive start, then bits of 16'h1235 (0x1234+0x0001 sum stream) LSB first, out_ready=1 -> dout=16'h1235, out_valid high for one cycle, 16 edges after start.
REQ-032 Bench SHALL drive 16'hFFFF then 16'h0000 back-to-back, with start on the edge after each completion, out_ready=1 -> two words, in order, dout exact.
REQ-033 Bench SHALL hold out_ready=0 and send 16'hA5A5 then 16'h5A5A -> dout=16'h5A5A, out_valid=1, and overrun=1 (with macro) or no overrun port (without macro).
REQ-034 Bench SHALL assert reset after 7 bits of 16'hBEEF, then send 16'h0042 -> no output for the aborted word, then dout=16'h0042; all outputs 0 during reset.
REQ-035 Bench SHALL pulse start during SHIFT at bit 5 of 16'h8001 -> ignored; dout=16'h8001 on schedule.
REQ-036 Bench SHALL raise out_ready on the same edge the next word completes -> out_valid stays 1 and dout holds the new word.

Source files
------------

// File: rtl/ser_collect.sv
// Serial-to-parallel word collector: LSB-first bits after a start pulse, single-slot output holding register.
// Optional sticky overrun flag enabled by defining SER_COLLECT_OVERRUN_EN.
module ser_collect #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             busy
`ifdef SER_COLLECT_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    SHIFT    = 1'b1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [0:0]       state_r;
    logic [0:0]       state_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    // Only WIDTH-1 bits are kept: the final bit goes straight from sin into dout.
    logic [WIDTH-2:0] shreg_r;
    logic [WIDTH-2:0] shreg_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_s;
    logic             valid_r;
    logic             valid_s;
    logic             busy_r;
    logic             done_s;

    // Next-state, bit counter and shift register.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shreg_s = shreg_r;
        word_s  = {sin, shreg_r};
        done_s  = (state_r == SHIFT) && (cnt_r == LAST_BIT);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shreg_s = word_s[WIDTH-1:1];
                if (done_s) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output slot: a completing word always wins over a same-edge accept.
    always_comb begin
        dout_s  = dout_r;
        valid_s = valid_r;
        if (done_s) begin
            dout_s  = word_s;
            valid_s = 1'b1;
        end else if (valid_r && out_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            shreg_r <= {(WIDTH-1){1'b0}};
            dout_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shreg_r <= shreg_s;
            dout_r  <= dout_s;
            valid_r <= valid_s;
            busy_r  <= (state_s == SHIFT);
        end
    end

    assign dout      = dout_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;

`ifdef SER_COLLECT_OVERRUN_EN
    logic overrun_r;
    logic overrun_s;

    // Sticky flag: a new word replaced one the consumer never took.
    always_comb begin
        if (done_s && valid_r && !out_ready) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // Overrun register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_s;
        end
    end

    assign overrun = overrun_r;
`endif

endmodule

// File: tb/tb_ser_collect.sv
// Scoreboard bench for ser_collect: directed scenarios plus randomized words and consumer stalls.
module tb_ser_collect;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sin;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic             busy;
`ifdef SER_COLLECT_OVERRUN_EN
    logic             overrun;
`endif

    ser_collect #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sin       (sin),
        .out_ready (out_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .busy      (busy)
`ifdef SER_COLLECT_OVERRUN_EN
        ,
        .overrun   (overrun)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one holding slot; an unaccepted word is replaced by the next one.
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_busy    = 1'b0;
    logic             exp_overrun = 1'b0;
    bit               rand_ready  = 1'b0;
    int               checks      = 0;
    int               errors      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_complete(input logic [WIDTH-1:0] w);
        if (exp_q.size() != 0) begin
            exp_q[0]    = w;
            exp_overrun = 1'b1;
        end else begin
            exp_q.push_back(w);
        end
        exp_busy = 1'b0;
    endtask

    // Monitor: compare every cycle, retire the slot on a handshake.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
            if (out_valid && exp_q.size() != 0) begin
                check("dout", {16'd0, dout}, {16'd0, exp_q[0]});
            end
`ifdef SER_COLLECT_OVERRUN_EN
            check("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
`endif
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Random consumer backpressure.
    initial begin
        forever begin
            @(posedge clk);
            if (rand_ready) begin
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            sin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit mid_glitch,
                             input bit last_start, input bit ready_at_last);
        start = 1'b1;
        sin   = 1'($urandom_range(0, 1));
        @(posedge clk);
        exp_busy = 1'b1;
        #1;
        for (int i = 0; i < WIDTH; i++) begin
            sin   = w[i];
            start = (mid_glitch && i == 5) || (last_start && i == WIDTH - 1);
            if (ready_at_last && i == WIDTH - 1) begin
                out_ready = 1'b1;
            end
            @(posedge clk);
            if (i == WIDTH - 1) begin
                model_complete(w);
            end
            #1;
        end
        start = 1'b0;
        sin   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, {16'd0, dout}, 32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef SER_COLLECT_OVERRUN_EN
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
`endif
    endtask

    logic [WIDTH-1:0] abort_w;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        sin       = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Single word, consumer always ready.
        out_ready = 1'b1;
        send_word(16'h1235, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Back-to-back words, start on the edge after completion.
        send_word(16'hFFFF, 1'b0, 1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Start held on the completion edge must be ignored.
        send_word(16'h3C3C, 1'b0, 1'b1, 1'b0);
        send_word(16'hC3C3, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Overwrite of an unaccepted word.
        out_ready = 1'b0;
        send_word(16'hA5A5, 1'b0, 1'b0, 1'b0);
        send_word(16'h5A5A, 1'b0, 1'b0, 1'b0);
        idle(3);
        out_ready = 1'b1;
        idle(2);

        // Accept on the same edge the next word completes.
        out_ready = 1'b0;
        send_word(16'h1111, 1'b0, 1'b0, 1'b0);
        idle(1);
        send_word(16'h2222, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Start pulse mid-word is ignored.
        send_word(16'h8001, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Reset part-way through a word.
        abort_w = 16'hBEEF;
        start   = 1'b1;
        @(posedge clk);
        exp_busy = 1'b1;
        #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sin = abort_w[i];
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        exp_q.delete();
        exp_busy    = 1'b0;
        exp_overrun = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        reset = 1'b0;
        idle(3);
        send_word(16'h0042, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomized words, gaps, glitches and backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_word(WIDTH'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
